// File: rtl/arty_pkg.sv
// rtl/arty_pkg.sv - boot sequencer state type and default timing constants
package arty_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RST_HOLD  = 2'd1,
        RELEASED  = 2'd2,
        RUN       = 2'd3
    } boot_state_e;

    // Defaults sized for a 50 MHz SoC clock: ~20 us reset hold, 1 ms debounce.
    localparam int unsigned DEF_SYNC_STAGES        = 2;
    localparam int unsigned DEF_RST_HOLD_CYCLES    = 1024;
    localparam int unsigned DEF_DEBOUNCE_CYCLES    = 50000;
    localparam int unsigned DEF_FETCH_DELAY_CYCLES = 16;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/arty_boot_seq_if.sv
// rtl/arty_boot_seq_if.sv - board-side inputs and SoC-side outputs of the boot sequencer
interface arty_boot_seq_if;

    logic                   pll_locked_i;
    logic                   fetch_sw_i;
    logic                   soft_rst_btn_i;
    logic                   soc_rst_n_o;
    logic                   fetch_enable_o;
    arty_pkg::boot_state_e  state_o;
    logic                   lock_lost_o;

    modport master (
        input  pll_locked_i, fetch_sw_i, soft_rst_btn_i,
        output soc_rst_n_o, fetch_enable_o, state_o, lock_lost_o
    );

    modport slave (
        output pll_locked_i, fetch_sw_i, soft_rst_btn_i,
        input  soc_rst_n_o, fetch_enable_o, state_o, lock_lost_o
    );

endinterface

// File: rtl/arty_debounce.sv
// rtl/arty_debounce.sv - synchroniser plus debounce for one asynchronous bouncing input
module arty_debounce #(
    parameter int unsigned SYNC_STAGES     = arty_pkg::DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = arty_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   d_s;

    assign d_s = sync_q[SYNC_STAGES-1];

    // Counter runs only while the synchronised input disagrees with q_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            q_o    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            if (d_s == q_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                q_o   <= d_s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arty_boot_seq.sv
// rtl/arty_boot_seq.sv - MMCM-lock to PULPino reset / fetch-enable boot sequencer
module arty_boot_seq
    import arty_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned FETCH_DELAY_CYCLES = DEF_FETCH_DELAY_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    arty_boot_seq_if.master bus
);

    localparam int unsigned CW = $clog2(max3(RST_HOLD_CYCLES, FETCH_DELAY_CYCLES,
                                             DEBOUNCE_CYCLES)) + 1;
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_DELAY_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   lock_s;
    logic                   sw_db;
    logic                   btn_db;
    logic                   btn_prev_q;
    logic                   btn_rise;

    boot_state_e            state_q;
    logic [CW-1:0]          cnt_q;
    logic                   soc_rst_n_q;
    logic                   fetch_en_q;
    logic                   lock_lost_q;

    arty_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk (clk),
        .rst (rst),
        .d_i (bus.fetch_sw_i),
        .q_o (sw_db)
    );

    arty_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk (clk),
        .rst (rst),
        .d_i (bus.soft_rst_btn_i),
        .q_o (btn_db)
    );

    assign lock_s   = lock_sync_q[SYNC_STAGES-1];
    assign btn_rise = btn_db & ~btn_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync_q <= '0;
            btn_prev_q  <= 1'b0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked_i};
            btn_prev_q  <= btn_db;
        end
    end

    // Outputs are written alongside every state change so they track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b0;
            fetch_en_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else if (state_q != WAIT_LOCK && !lock_s) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b0;
            fetch_en_q  <= 1'b0;
            lock_lost_q <= 1'b1;
        end else if (state_q != WAIT_LOCK && btn_rise) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            soc_rst_n_q <= 1'b0;
            fetch_en_q  <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= RST_HOLD;
                        cnt_q   <= '0;
                    end
                end
                RST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q     <= RELEASED;
                        cnt_q       <= '0;
                        soc_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASED: begin
                    if (!sw_db) begin
                        cnt_q <= '0;
                    end else if (cnt_q == FETCH_LAST) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        fetch_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!sw_db) begin
                        state_q    <= RELEASED;
                        cnt_q      <= '0;
                        fetch_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.soc_rst_n_o    = soc_rst_n_q;
    assign bus.fetch_enable_o = fetch_en_q;
    assign bus.state_o        = state_q;
    assign bus.lock_lost_o    = lock_lost_q;

endmodule
